// File: rtl/rtc_lcd_frame_pkg.sv
// Shared constants and types for the time-of-day counter and its LCD frame sequencer.
// Character codes, LCD command bytes, run/pause state encoding and a field clamp helper.
package rtc_lcd_frame_pkg;

  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam logic [7:0] LCD_IDLE      = 8'h02;

  localparam logic [7:0] ASCII_BLANK   = 8'h20;
  localparam logic [7:0] ASCII_COLON   = 8'h3A;
  localparam logic [7:0] ASCII_A       = 8'h41;
  localparam logic [7:0] ASCII_P       = 8'h50;
  localparam logic [7:0] ASCII_M       = 8'h4D;
  localparam logic [7:0] ASCII_ARROW   = 8'h19;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } run_state_e;

  typedef struct packed {
    logic       rw;
    logic       rs;
    logic [7:0] data;
  } lcd_bus_t;

  function automatic logic [6:0] clamp7(input logic [6:0] v, input logic [6:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/rtc_lcd_frame_bin2_ascii.sv
// Splits a 0..99 binary value into its two ASCII decimal digit characters.
module rtc_lcd_frame_bin2_ascii
  import rtc_lcd_frame_pkg::*;
(
  input  logic [6:0] bin_i,
  output logic [7:0] tens_o,
  output logic [7:0] ones_o
);

  logic [6:0] tens;
  logic [6:0] ones;

  always_comb begin
    tens   = bin_i / 7'd10;
    ones   = bin_i - (tens * 7'd10);
    tens_o = ASCII_ZERO + {1'b0, tens};
    ones_o = ASCII_ZERO + {1'b0, ones};
  end

endmodule

// File: rtl/rtc_lcd_frame.sv
// Time-of-day counter (12 h / 24 h, pause, load) that streams one LCD frame per pass.
// Bus handshake: none; the LCD driver mux consumes RW/RS/DATA every cycle while the frame runs.
module rtc_lcd_frame
  import rtc_lcd_frame_pkg::*;
#(
  parameter int CLK_PER_SEC = 1000,
  parameter int BLINK_ON    = 500,
  parameter int FRAME_SLOTS = 36
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic       DISP_ON,
  input  logic       FMT24,
  input  logic       PAUSE_REQ,
  input  logic       RESUME_REQ,
  input  logic       LOAD,
  input  logic       LOAD_PM,
  input  logic [6:0] LOAD_H,
  input  logic [6:0] LOAD_M,
  input  logic [6:0] LOAD_S,
  input  logic       CURSOR_EN,
  input  logic [3:0] CURSOR_POS,
  output logic       RW_OUTPUT,
  output logic       RS_OUTPUT,
  output logic [7:0] DATA_OUTPUT,
  output logic [6:0] HOUR,
  output logic [6:0] MIN,
  output logic [6:0] SEC,
  output logic       PM,
  output logic       SEC_TICK,
  output logic       DAY_WRAP,
  output logic       FRAME_DONE
);

  localparam int TW = $clog2(CLK_PER_SEC);
  localparam int SW = $clog2(FRAME_SLOTS);
  localparam logic [TW-1:0] TICK_MAX  = TW'(CLK_PER_SEC - 1);
  localparam logic [TW-1:0] BLINK_T   = TW'(BLINK_ON);
  localparam logic [SW-1:0] SLOT_LAST = SW'(FRAME_SLOTS - 1);

  logic [6:0]    hour_q, min_q, sec_q;
  logic          pm_q;
  logic [TW-1:0] tick_q;
  run_state_e    run_q;
  logic          fmt_q;
  logic          sec_tick_q, day_wrap_q;
  logic [SW-1:0] slot_q;
  lcd_bus_t      bus_q;
  logic          frame_done_q;

  logic [6:0]    hour_d, min_d, sec_d;
  logic          pm_d;
  logic [TW-1:0] tick_d;
  logic          sec_tick_d, day_wrap_d;
  logic [6:0]    h_eff, hlim;
  logic          pm_eff;

  // Hours are first re-expressed in the new format so a tick in the same cycle ripples correctly.
  always_comb begin
    h_eff  = hour_q;
    pm_eff = pm_q;
    if (FMT24 != fmt_q) begin
      if (FMT24) begin
        h_eff = pm_q ? (hour_q + 7'd12) : hour_q;
      end else begin
        pm_eff = (hour_q >= 7'd12);
        h_eff  = (hour_q >= 7'd12) ? (hour_q - 7'd12) : hour_q;
      end
    end
    hlim       = FMT24 ? 7'd23 : 7'd11;
    hour_d     = h_eff;
    min_d      = min_q;
    sec_d      = sec_q;
    pm_d       = pm_eff;
    tick_d     = tick_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    if (LOAD) begin
      tick_d = '0;
      sec_d  = clamp7(LOAD_S, 7'd59);
      min_d  = clamp7(LOAD_M, 7'd59);
      hour_d = clamp7(LOAD_H, hlim);
      pm_d   = FMT24 ? (hour_d >= 7'd12) : LOAD_PM;
    end else if (run_q == ST_RUN) begin
      if (tick_q == TICK_MAX) begin
        tick_d     = '0;
        sec_tick_d = 1'b1;
        if (sec_q == 7'd59) begin
          sec_d = 7'd0;
          if (min_q == 7'd59) begin
            min_d = 7'd0;
            if (h_eff == hlim) begin
              hour_d     = 7'd0;
              pm_d       = FMT24 ? 1'b0 : ~pm_eff;
              day_wrap_d = FMT24 ? 1'b1 : pm_eff;
            end else begin
              hour_d = h_eff + 7'd1;
              if (FMT24) pm_d = (hour_d >= 7'd12);
            end
          end else begin
            min_d = min_q + 7'd1;
          end
        end else begin
          sec_d = sec_q + 7'd1;
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  logic [6:0] hour_disp;
  logic [7:0] h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
  logic [7:0] colon_ch;

  assign hour_disp = (!fmt_q && hour_q == 7'd0) ? 7'd12 : hour_q;
  assign colon_ch  = (tick_q < BLINK_T) ? ASCII_COLON : ASCII_BLANK;

  rtc_lcd_frame_bin2_ascii u_hour (.bin_i(hour_disp), .tens_o(h_tens), .ones_o(h_ones));
  rtc_lcd_frame_bin2_ascii u_min  (.bin_i(min_q),     .tens_o(m_tens), .ones_o(m_ones));
  rtc_lcd_frame_bin2_ascii u_sec  (.bin_i(sec_q),     .tens_o(s_tens), .ones_o(s_ones));

  lcd_bus_t bus_d;
  int       slot_n;

  always_comb begin
    slot_n      = int'(slot_q);
    bus_d.rw    = 1'b0;
    bus_d.rs    = 1'b1;
    bus_d.data  = ASCII_BLANK;
    if (slot_n == 0) begin
      bus_d.rs   = 1'b0;
      bus_d.data = LCD_CMD_LINE1;
    end else if (slot_n <= 16) begin
      if (CURSOR_EN && (int'(CURSOR_POS) == slot_n - 1)) bus_d.data = ASCII_ARROW;
    end else if (slot_n == 17) begin
      bus_d.rs   = 1'b0;
      bus_d.data = LCD_CMD_LINE2;
    end else begin
      case (slot_n)
        22:      bus_d.data = fmt_q ? ASCII_BLANK : (pm_q ? ASCII_P : ASCII_A);
        23:      bus_d.data = fmt_q ? ASCII_BLANK : ASCII_M;
        25:      bus_d.data = h_tens;
        26:      bus_d.data = h_ones;
        27:      bus_d.data = colon_ch;
        28:      bus_d.data = m_tens;
        29:      bus_d.data = m_ones;
        30:      bus_d.data = colon_ch;
        31:      bus_d.data = s_tens;
        32:      bus_d.data = s_ones;
        default: bus_d.data = ASCII_BLANK;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hour_q       <= 7'd0;
      min_q        <= 7'd0;
      sec_q        <= 7'd0;
      pm_q         <= 1'b0;
      tick_q       <= '0;
      run_q        <= ST_RUN;
      fmt_q        <= 1'b0;
      sec_tick_q   <= 1'b0;
      day_wrap_q   <= 1'b0;
      slot_q       <= '0;
      bus_q        <= '{rw: 1'b1, rs: 1'b1, data: LCD_IDLE};
      frame_done_q <= 1'b0;
    end else begin
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      pm_q       <= pm_d;
      tick_q     <= tick_d;
      fmt_q      <= FMT24;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
      // Only the request that would change state is looked at, so it wins a same-cycle collision.
      if (run_q == ST_RUN) begin
        if (PAUSE_REQ) run_q <= ST_PAUSED;
      end else if (RESUME_REQ) begin
        run_q <= ST_RUN;
      end
      if (EN && DISP_ON) begin
        bus_q        <= bus_d;
        frame_done_q <= (slot_q == SLOT_LAST);
        slot_q       <= (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
      end else begin
        bus_q        <= '{rw: 1'b1, rs: 1'b1, data: LCD_IDLE};
        frame_done_q <= 1'b0;
        slot_q       <= '0;
      end
    end
  end

  assign RW_OUTPUT   = bus_q.rw;
  assign RS_OUTPUT   = bus_q.rs;
  assign DATA_OUTPUT = bus_q.data;
  assign HOUR        = hour_q;
  assign MIN         = min_q;
  assign SEC         = sec_q;
  assign PM          = pm_q;
  assign SEC_TICK    = sec_tick_q;
  assign DAY_WRAP    = day_wrap_q;
  assign FRAME_DONE  = frame_done_q;

endmodule

// File: tb/tb_rtc_lcd_frame.sv
// Bench for rtc_lcd_frame: load table, directed multi-cycle sequences, and a random run
// compared every cycle against a seconds-of-day reference model.
module tb_rtc_lcd_frame;

  localparam int CPS   = 1000;
  localparam int BLINK = 500;
  localparam int SLOTS = 36;

  logic       CLK = 1'b0;
  logic       RESET, EN, DISP_ON, FMT24, PAUSE_REQ, RESUME_REQ, LOAD, LOAD_PM;
  logic [6:0] LOAD_H, LOAD_M, LOAD_S;
  logic       CURSOR_EN;
  logic [3:0] CURSOR_POS;
  logic       RW_OUTPUT, RS_OUTPUT;
  logic [7:0] DATA_OUTPUT;
  logic [6:0] HOUR, MIN, SEC;
  logic       PM, SEC_TICK, DAY_WRAP, FRAME_DONE;

  rtc_lcd_frame #(.CLK_PER_SEC(CPS), .BLINK_ON(BLINK), .FRAME_SLOTS(SLOTS)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DISP_ON(DISP_ON), .FMT24(FMT24),
    .PAUSE_REQ(PAUSE_REQ), .RESUME_REQ(RESUME_REQ), .LOAD(LOAD), .LOAD_PM(LOAD_PM),
    .LOAD_H(LOAD_H), .LOAD_M(LOAD_M), .LOAD_S(LOAD_S),
    .CURSOR_EN(CURSOR_EN), .CURSOR_POS(CURSOR_POS),
    .RW_OUTPUT(RW_OUTPUT), .RS_OUTPUT(RS_OUTPUT), .DATA_OUTPUT(DATA_OUTPUT),
    .HOUR(HOUR), .MIN(MIN), .SEC(SEC), .PM(PM),
    .SEC_TICK(SEC_TICK), .DAY_WRAP(DAY_WRAP), .FRAME_DONE(FRAME_DONE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is kept as seconds since midnight; 12/24 h is only a way of printing it.
  int   m_tod, m_tick, m_slot;
  bit   m_paused, m_fmt;
  bit   e_rw, e_rs, e_done, e_sec_tick, e_day_wrap;
  logic [7:0] e_data;

  task automatic m_reset();
    m_tod = 0; m_tick = 0; m_slot = 0; m_paused = 0; m_fmt = 0;
    e_rw = 1; e_rs = 1; e_data = 8'h02; e_done = 0; e_sec_tick = 0; e_day_wrap = 0;
  endtask

  function automatic logic [7:0] frame_byte(input int s);
    string l2, ap, col;
    int    h24, hd;
    if (s == 0) return 8'h80;
    if (s <= 16) return (CURSOR_EN && int'(CURSOR_POS) == s - 1) ? 8'h19 : 8'h20;
    if (s == 17) return 8'hC0;
    h24 = m_tod / 3600;
    if (m_fmt) begin
      ap = "  ";
      hd = h24;
    end else begin
      if (h24 >= 12) ap = "PM"; else ap = "AM";
      hd = (h24 % 12 == 0) ? 12 : h24 % 12;
    end
    if (m_tick < BLINK) col = ":"; else col = " ";
    l2 = $sformatf("    %s %02d%s%02d%s%02d", ap, hd, col, (m_tod / 60) % 60, col, m_tod % 60);
    if (s - 18 < l2.len()) return l2[s - 18];
    return 8'h20;
  endfunction

  task automatic model_step();
    int h24, cm, cs;
    if (!RESET) begin
      m_reset();
      return;
    end
    if (EN && DISP_ON) begin
      e_rw   = 0;
      e_rs   = (m_slot == 0 || m_slot == 17) ? 0 : 1;
      e_data = frame_byte(m_slot);
      e_done = (m_slot == SLOTS - 1);
      m_slot = (m_slot + 1) % SLOTS;
    end else begin
      e_rw = 1; e_rs = 1; e_data = 8'h02; e_done = 0; m_slot = 0;
    end
    e_sec_tick = 0;
    e_day_wrap = 0;
    if (LOAD) begin
      cs = (LOAD_S > 59) ? 59 : int'(LOAD_S);
      cm = (LOAD_M > 59) ? 59 : int'(LOAD_M);
      if (FMT24) h24 = (LOAD_H > 23) ? 23 : int'(LOAD_H);
      else       h24 = ((LOAD_H > 11) ? 11 : int'(LOAD_H)) + (LOAD_PM ? 12 : 0);
      m_tod  = (h24 * 60 + cm) * 60 + cs;
      m_tick = 0;
    end else if (!m_paused) begin
      if (m_tick == CPS - 1) begin
        m_tick     = 0;
        e_sec_tick = 1;
        e_day_wrap = (m_tod == 86399);
        m_tod      = (m_tod + 1) % 86400;
      end else begin
        m_tick++;
      end
    end
    if (m_paused && RESUME_REQ)      m_paused = 0;
    else if (!m_paused && PAUSE_REQ) m_paused = 1;
    m_fmt = FMT24;
  endtask

  task automatic compare_all();
    int h24;
    h24 = m_tod / 3600;
    chk("model RW", RW_OUTPUT, e_rw);
    chk("model RS", RS_OUTPUT, e_rs);
    chk("model DATA", DATA_OUTPUT, e_data);
    chk("model FRAME_DONE", FRAME_DONE, e_done);
    chk("model HOUR", HOUR, m_fmt ? h24 : h24 % 12);
    chk("model MIN", MIN, (m_tod / 60) % 60);
    chk("model SEC", SEC, m_tod % 60);
    chk("model PM", PM, h24 >= 12);
    chk("model SEC_TICK", SEC_TICK, e_sec_tick);
    chk("model DAY_WRAP", DAY_WRAP, e_day_wrap);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  logic [7:0] fr_data[SLOTS];
  bit         fr_rs[SLOTS];
  bit         fr_done[SLOTS];

  task automatic capture_frame();
    EN = 1; DISP_ON = 0;
    cycle();
    DISP_ON = 1;
    for (int k = 0; k < SLOTS; k++) begin
      cycle();
      fr_data[k] = DATA_OUTPUT;
      fr_rs[k]   = RS_OUTPUT;
      fr_done[k] = FRAME_DONE;
    end
  endtask

  task automatic load_time(input bit fmt, input bit pm, input int h, input int m, input int s);
    FMT24 = fmt; LOAD_PM = pm; LOAD_H = 7'(h); LOAD_M = 7'(m); LOAD_S = 7'(s); LOAD = 1;
    cycle();
    LOAD = 0;
  endtask

  typedef struct {
    bit fmt24; bit pm; int h; int m; int s;
    int eh; int em; int es; bit epm;
  } load_vec_t;

  load_vec_t vecs[9];

  initial begin
    int n, cnt;
    vecs[0] = '{0, 1, 11, 59, 59, 11, 59, 59, 1};
    vecs[1] = '{0, 0, 40, 75, 60, 11, 59, 59, 0};
    vecs[2] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[3] = '{1, 0, 23, 59, 59, 23, 59, 59, 1};
    vecs[4] = '{1, 1, 127, 127, 127, 23, 59, 59, 1};
    vecs[5] = '{1, 1, 5, 7, 9, 5, 7, 9, 0};
    vecs[6] = '{1, 0, 12, 0, 0, 12, 0, 0, 1};
    vecs[7] = '{0, 0, 12, 30, 30, 11, 30, 30, 0};
    vecs[8] = '{1, 0, 0, 60, 59, 0, 59, 59, 0};

    RESET = 0; EN = 1; DISP_ON = 1; FMT24 = 0; PAUSE_REQ = 0; RESUME_REQ = 0;
    LOAD = 0; LOAD_PM = 0; LOAD_H = 0; LOAD_M = 0; LOAD_S = 0;
    CURSOR_EN = 0; CURSOR_POS = 0;
    m_reset();

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("reset HOUR", HOUR, 0);
    chk("reset MIN", MIN, 0);
    chk("reset SEC", SEC, 0);
    chk("reset PM", PM, 0);
    chk("reset RW", RW_OUTPUT, 1);
    chk("reset RS", RS_OUTPUT, 1);
    chk("reset DATA", DATA_OUTPUT, 8'h02);
    chk("reset SEC_TICK", SEC_TICK, 0);
    chk("reset DAY_WRAP", DAY_WRAP, 0);
    chk("reset FRAME_DONE", FRAME_DONE, 0);
    RESET = 1;
    cycle();

    // load / clamp table
    foreach (vecs[i]) begin
      load_time(vecs[i].fmt24, vecs[i].pm, vecs[i].h, vecs[i].m, vecs[i].s);
      chk($sformatf("load[%0d] HOUR", i), HOUR, vecs[i].eh);
      chk($sformatf("load[%0d] MIN", i), MIN, vecs[i].em);
      chk($sformatf("load[%0d] SEC", i), SEC, vecs[i].es);
      chk($sformatf("load[%0d] PM", i), PM, vecs[i].epm);
    end

    // 12 h rollover
    load_time(0, 1, 11, 59, 59);
    n = 0;
    do begin cycle(); n++; end while (!DAY_WRAP && n < 3 * CPS);
    chk("12h wrap latency", n, CPS);
    chk("12h wrap HOUR", HOUR, 0);
    chk("12h wrap MIN", MIN, 0);
    chk("12h wrap SEC", SEC, 0);
    chk("12h wrap PM", PM, 0);
    chk("12h wrap SEC_TICK", SEC_TICK, 1);
    cycle();
    chk("12h DAY_WRAP one cycle", DAY_WRAP, 0);
    capture_frame();
    chk("12h slot25", fr_data[25], "1");
    chk("12h slot26", fr_data[26], "2");
    chk("12h slot22", fr_data[22], "A");
    chk("12h slot23", fr_data[23], "M");

    // 24 h rollover
    load_time(1, 0, 23, 59, 59);
    n = 0;
    do begin cycle(); n++; end while (!DAY_WRAP && n < 3 * CPS);
    chk("24h wrap latency", n, CPS);
    chk("24h wrap HOUR", HOUR, 0);
    chk("24h wrap MIN", MIN, 0);
    chk("24h wrap SEC", SEC, 0);
    chk("24h wrap PM", PM, 0);
    capture_frame();
    chk("24h slot22", fr_data[22], 8'h20);
    chk("24h slot23", fr_data[23], 8'h20);
    chk("24h slot25", fr_data[25], "0");
    chk("24h slot26", fr_data[26], "0");

    // pause at tick 300, freeze, resume
    load_time(1, 0, 10, 20, 30);
    n = 0;
    while (m_tick != 300 && n < 2 * CPS) begin cycle(); n++; end
    chk("pause reach tick 300", m_tick, 300);
    PAUSE_REQ = 1;
    cycle();
    PAUSE_REQ = 0;
    cnt = 0;
    for (int k = 0; k < 5000; k++) begin
      cycle();
      if (SEC_TICK) cnt++;
    end
    chk("paused SEC_TICK count", cnt, 0);
    chk("paused HOUR", HOUR, 10);
    chk("paused MIN", MIN, 20);
    chk("paused SEC", SEC, 30);
    capture_frame();
    chk("paused colon slot27", fr_data[27], 8'h3A);
    chk("paused colon slot30", fr_data[30], 8'h3A);
    chk("paused slot32", fr_data[32], "0");
    RESUME_REQ = 1;
    cycle();
    RESUME_REQ = 0;
    n = 1;
    while (!SEC_TICK && n < 3 * CPS) begin cycle(); n++; end
    chk("resume SEC_TICK latency", n, 700);
    chk("resume SEC", SEC, 31);

    // clamp with pause in the same cycle
    PAUSE_REQ = 1;
    load_time(0, 0, 40, 75, 60);
    PAUSE_REQ = 0;
    chk("clamp HOUR", HOUR, 11);
    chk("clamp MIN", MIN, 59);
    chk("clamp SEC", SEC, 59);
    repeat (2 * CPS) cycle();
    chk("clamp paused SEC", SEC, 59);
    chk("clamp paused HOUR", HOUR, 11);
    RESUME_REQ = 1;
    cycle();
    RESUME_REQ = 0;

    // frame layout and cadence
    CURSOR_EN = 1; CURSOR_POS = 4'd3;
    capture_frame();
    chk("frame slot0 RS", fr_rs[0], 0);
    chk("frame slot0 DATA", fr_data[0], 8'h80);
    chk("frame slot1 DATA", fr_data[1], 8'h20);
    chk("frame slot4 arrow", fr_data[4], 8'h19);
    chk("frame slot5 DATA", fr_data[5], 8'h20);
    chk("frame slot17 RS", fr_rs[17], 0);
    chk("frame slot17 DATA", fr_data[17], 8'hC0);
    chk("frame slot35 DONE", fr_done[35], 1);
    chk("frame slot34 DONE", fr_done[34], 0);
    cnt = 0;
    for (int k = 0; k < SLOTS; k++) begin
      cycle();
      if (FRAME_DONE) cnt++;
    end
    chk("FRAME_DONE per 36 cycles", cnt, 1);
    repeat (10) cycle();
    DISP_ON = 0;
    cycle();
    chk("disp off RW", RW_OUTPUT, 1);
    chk("disp off RS", RS_OUTPUT, 1);
    chk("disp off DATA", DATA_OUTPUT, 8'h02);

    // asynchronous reset mid-frame
    DISP_ON = 1;
    repeat (10) cycle();
    RESET = 0;
    #2;
    chk("async reset RW", RW_OUTPUT, 1);
    chk("async reset DATA", DATA_OUTPUT, 8'h02);
    chk("async reset HOUR", HOUR, 0);
    chk("async reset MIN", MIN, 0);
    cycle();
    RESET = 1;
    cycle();
    chk("restart slot0 RS", RS_OUTPUT, 0);
    chk("restart slot0 DATA", DATA_OUTPUT, 8'h80);

    // randomized run against the model
    for (int i = 0; i < 15000; i++) begin
      EN         = ($urandom_range(0, 299) != 0);
      DISP_ON    = ($urandom_range(0, 299) != 0);
      PAUSE_REQ  = ($urandom_range(0, 499) == 0);
      RESUME_REQ = ($urandom_range(0, 299) == 0);
      LOAD       = ($urandom_range(0, 699) == 0);
      LOAD_PM    = 1'($urandom_range(0, 1));
      LOAD_H     = $urandom_range(0, 2) == 0 ? 7'($urandom_range(0, 127)) : 7'($urandom_range(10, 12) + 11 * $urandom_range(0, 1));
      LOAD_M     = $urandom_range(0, 2) == 0 ? 7'($urandom_range(0, 127)) : 7'd59;
      LOAD_S     = $urandom_range(0, 2) == 0 ? 7'($urandom_range(0, 127)) : 7'($urandom_range(58, 60));
      if ($urandom_range(0, 1499) == 0) FMT24 = ~FMT24;
      if ($urandom_range(0, 99) == 0) begin
        CURSOR_EN  = 1'($urandom_range(0, 1));
        CURSOR_POS = 4'($urandom_range(0, 15));
      end
      cycle();
    end
    LOAD = 0; PAUSE_REQ = 0; RESUME_REQ = 0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
